// File: rtl/alu_scheduler.sv
// Round-robin scheduler that serialises requester operations onto a single
// 1-cycle ALU, with illegal-function and ALU-timeout error responses.
module alu_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 in_clock,
    input  logic                 in_reset,
    input  logic [NUM_REQ-1:0]   in_req_valid,
    output logic [NUM_REQ-1:0]   out_req_ready,
    input  logic [8*NUM_REQ-1:0] in_req_lhs,
    input  logic [8*NUM_REQ-1:0] in_req_rhs,
    input  logic [3*NUM_REQ-1:0] in_req_function,
    output logic                 out_alu_valid,
    output logic [7:0]           out_alu_lhs,
    output logic [7:0]           out_alu_rhs,
    output logic [2:0]           out_alu_function,
    input  logic                 in_alu_valid,
    input  logic [7:0]           in_alu_result,
    output logic                 out_rsp_valid,
    output logic [IDW-1:0]       out_rsp_id,
    output logic [7:0]           out_rsp_result,
    output logic                 out_rsp_error,
    output logic                 out_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] winner;
    logic           found;
    int             idx;
    logic           any_valid;
    logic [7:0]     win_lhs;
    logic [7:0]     win_rhs;
    logic [2:0]     win_function;
    logic           win_illegal;
    logic           timed_out;
    logic [7:0]     wait_count;
    logic [IDW-1:0] lat_id;
    logic [7:0]     lat_lhs;
    logic [7:0]     lat_rhs;
    logic [2:0]     lat_function;
    logic [7:0]     lat_result;
    logic           lat_error;

    // Round-robin search starting just after the previous grant.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(last_grant) + 1 + k) % NUM_REQ;
            if (!found && in_req_valid[idx]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any_valid    = |in_req_valid;
    assign win_lhs      = in_req_lhs[8*int'(winner) +: 8];
    assign win_rhs      = in_req_rhs[8*int'(winner) +: 8];
    assign win_function = in_req_function[3*int'(winner) +: 3];
    assign win_illegal  = (win_function == 3'b111);
    assign timed_out    = (wait_count == 8'(TIMEOUT));

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_valid) next_state = win_illegal ? RESPOND : ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (in_alu_valid || timed_out) next_state = RESPOND;
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ready is also masked by reset so every output reads 0 while it is held.
    always_comb begin
        out_req_ready  = '0;
        out_alu_valid  = 1'b0;
        out_rsp_valid  = 1'b0;
        out_rsp_id     = '0;
        out_rsp_result = '0;
        out_rsp_error  = 1'b0;
        out_busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (any_valid && !in_reset) out_req_ready[winner] = 1'b1;
            end
            ISSUE: out_alu_valid = 1'b1;
            RESPOND: begin
                out_rsp_valid  = 1'b1;
                out_rsp_id     = lat_id;
                out_rsp_result = lat_result;
                out_rsp_error  = lat_error;
            end
            default: ;
        endcase
    end

    assign out_alu_lhs      = lat_lhs;
    assign out_alu_rhs      = lat_rhs;
    assign out_alu_function = lat_function;

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            last_grant   <= IDW'(NUM_REQ - 1);
            wait_count   <= '0;
            lat_id       <= '0;
            lat_lhs      <= '0;
            lat_rhs      <= '0;
            lat_function <= '0;
            lat_result   <= '0;
            lat_error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        lat_id       <= winner;
                        lat_lhs      <= win_lhs;
                        lat_rhs      <= win_rhs;
                        lat_function <= win_function;
                        lat_result   <= '0;
                        lat_error    <= win_illegal;
                    end
                end
                ISSUE: wait_count <= 8'd1;
                WAIT: begin
                    // A result arriving on the timeout cycle still counts as success.
                    if (in_alu_valid) begin
                        lat_result <= in_alu_result;
                        lat_error  <= 1'b0;
                    end else if (timed_out) begin
                        lat_result <= '0;
                        lat_error  <= 1'b1;
                    end else begin
                        wait_count <= wait_count + 8'd1;
                    end
                end
                RESPOND: begin
                    last_grant <= lat_id;
                    wait_count <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a 1-cycle ALU stub that can be muted
// to force timeouts.
module tb_alu_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_lhs;
    logic [31:0] req_rhs;
    logic [11:0] req_function;
    logic        alu_valid;
    logic [7:0]  alu_lhs;
    logic [7:0]  alu_rhs;
    logic [2:0]  alu_function;
    logic        alu_valid_in;
    logic [7:0]  alu_result_in;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_result;
    logic        rsp_error;
    logic        busy;

    logic        alu_enable;
    logic        stub_valid;
    logic [7:0]  stub_result;
    logic        manual_valid;
    logic [7:0]  manual_result;

    int vectors = 0;
    int miscompares = 0;

    alu_scheduler #(.NUM_REQ(4), .TIMEOUT(15)) dut (
        .in_clock         (clock),
        .in_reset         (reset),
        .in_req_valid     (req_valid),
        .out_req_ready    (req_ready),
        .in_req_lhs       (req_lhs),
        .in_req_rhs       (req_rhs),
        .in_req_function  (req_function),
        .out_alu_valid    (alu_valid),
        .out_alu_lhs      (alu_lhs),
        .out_alu_rhs      (alu_rhs),
        .out_alu_function (alu_function),
        .in_alu_valid     (alu_valid_in),
        .in_alu_result    (alu_result_in),
        .out_rsp_valid    (rsp_valid),
        .out_rsp_id       (rsp_id),
        .out_rsp_result   (rsp_result),
        .out_rsp_error    (rsp_error),
        .out_busy         (busy)
    );

    always #5 clock = ~clock;

    // ALU stub: answers one cycle after each issue strobe unless muted.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            stub_valid  <= 1'b0;
            stub_result <= 8'h00;
        end else begin
            stub_valid <= alu_enable && alu_valid;
            case (alu_function)
                3'b000:  stub_result <= alu_lhs + alu_rhs;
                3'b001:  stub_result <= alu_lhs - alu_rhs;
                3'b010:  stub_result <= alu_lhs & alu_rhs;
                3'b011:  stub_result <= alu_lhs | alu_rhs;
                3'b100:  stub_result <= alu_lhs ^ alu_rhs;
                3'b101:  stub_result <= alu_lhs << alu_rhs[2:0];
                3'b110:  stub_result <= alu_lhs >> alu_rhs[2:0];
                default: stub_result <= 8'h00;
            endcase
        end
    end

    assign alu_valid_in  = stub_valid | manual_valid;
    assign alu_result_in = manual_valid ? manual_result : stub_result;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int idx, input logic [7:0] lhs,
                                  input logic [7:0] rhs, input logic [2:0] fn);
        req_lhs[8*idx +: 8]      = lhs;
        req_rhs[8*idx +: 8]      = rhs;
        req_function[3*idx +: 3] = fn;
    endtask

    // Called in the acceptance cycle T; returns in cycle T+4 (IDLE again).
    task automatic run_op(input string tag, input int idx, input logic [7:0] expected);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        check_output({tag, "_ready"}, req_ready, onehot);
        tick();
        check_output({tag, "_alu_valid"}, alu_valid, 1'b1);
        check_output({tag, "_busy"}, busy, 1'b1);
        tick();
        check_output({tag, "_no_early_rsp"}, rsp_valid, 1'b0);
        tick();
        check_output({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        check_output({tag, "_rsp_id"}, rsp_id, idx);
        check_output({tag, "_rsp_result"}, rsp_result, expected);
        check_output({tag, "_rsp_error"}, rsp_error, 1'b0);
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        req_valid = 4'b0000;
        req_lhs = '0;
        req_rhs = '0;
        req_function = '0;
        alu_enable = 1'b1;
        manual_valid = 1'b0;
        manual_result = 8'h00;

        // Reset state, with a request already pending.
        #12;
        apply_stimulus(0, 8'h05, 8'h03, 3'b000);
        req_valid = 4'b0001;
        #1;
        check_output("reset_ready", req_ready, 4'b0000);
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_rsp_valid", rsp_valid, 1'b0);
        check_output("reset_alu_valid", alu_valid, 1'b0);
        check_output("reset_alu_lhs", alu_lhs, 8'h00);
        reset = 1'b0;
        #1;

        // 05 + 03 from requester 0, with operand latch check in ISSUE.
        check_output("first_ready", req_ready, 4'b0001);
        check_output("first_idle_busy", busy, 1'b0);
        tick();
        check_output("first_alu_lhs", alu_lhs, 8'h05);
        check_output("first_alu_rhs", alu_rhs, 8'h03);
        check_output("first_alu_fn", alu_function, 3'b000);
        check_output("first_ready_issue", req_ready, 4'b0000);
        req_valid = 4'b0000;
        tick();
        check_output("first_alu_valid_wait", alu_valid, 1'b0);
        tick();
        check_output("first_rsp_valid", rsp_valid, 1'b1);
        check_output("first_rsp_id", rsp_id, 2'd0);
        check_output("first_rsp_result", rsp_result, 8'h08);
        check_output("first_rsp_error", rsp_error, 1'b0);
        tick();
        check_output("first_after_rsp_valid", rsp_valid, 1'b0);
        check_output("first_after_rsp_result", rsp_result, 8'h00);
        check_output("first_after_busy", busy, 1'b0);

        // F0 + 20 wraps to 10 (requester 3).
        apply_stimulus(3, 8'hF0, 8'h20, 3'b000);
        req_valid = 4'b1000;
        #1;
        run_op("wrap", 3, 8'h10);
        req_valid = 4'b0000;

        // All four continuously valid after a grant to 3: 0,1,2,3,0.
        apply_stimulus(0, 8'h10, 8'h03, 3'b001);
        apply_stimulus(1, 8'hAC, 8'h0F, 3'b010);
        apply_stimulus(2, 8'hA0, 8'h05, 3'b011);
        apply_stimulus(3, 8'hFF, 8'h0F, 3'b100);
        req_valid = 4'b1111;
        #1;
        run_op("rr0", 0, 8'h0D);
        run_op("rr1", 1, 8'h0C);
        run_op("rr2", 2, 8'hA5);
        run_op("rr3", 3, 8'hF0);
        run_op("rr4", 0, 8'h0D);
        req_valid = 4'b0000;
        #1;

        // Illegal function from requester 2: error response one cycle later.
        apply_stimulus(2, 8'h12, 8'h34, 3'b111);
        req_valid = 4'b0100;
        #1;
        check_output("illegal_ready", req_ready, 4'b0100);
        tick();
        check_output("illegal_rsp_valid", rsp_valid, 1'b1);
        check_output("illegal_rsp_id", rsp_id, 2'd2);
        check_output("illegal_rsp_error", rsp_error, 1'b1);
        check_output("illegal_rsp_result", rsp_result, 8'h00);
        check_output("illegal_alu_valid", alu_valid, 1'b0);
        req_valid = 4'b0000;
        tick();
        check_output("illegal_after_busy", busy, 1'b0);
        check_output("illegal_after_alu_valid", alu_valid, 1'b0);

        // Muted ALU: timeout after 15 WAIT cycles, late strobe ignored.
        alu_enable = 1'b0;
        apply_stimulus(1, 8'h11, 8'h22, 3'b000);
        req_valid = 4'b0010;
        #1;
        check_output("timeout_ready", req_ready, 4'b0010);
        tick();
        check_output("timeout_alu_valid", alu_valid, 1'b1);
        req_valid = 4'b0000;
        repeat (15) tick();
        check_output("timeout_last_wait_busy", busy, 1'b1);
        check_output("timeout_last_wait_rsp", rsp_valid, 1'b0);
        tick();
        check_output("timeout_rsp_valid", rsp_valid, 1'b1);
        check_output("timeout_rsp_id", rsp_id, 2'd1);
        check_output("timeout_rsp_error", rsp_error, 1'b1);
        check_output("timeout_rsp_result", rsp_result, 8'h00);
        manual_valid = 1'b1;
        manual_result = 8'h55;
        tick();
        check_output("late_valid_rsp", rsp_valid, 1'b0);
        check_output("late_valid_busy", busy, 1'b0);
        manual_valid = 1'b0;
        tick();
        check_output("late_valid_rsp_next", rsp_valid, 1'b0);
        check_output("late_valid_busy_next", busy, 1'b0);

        // Reset while in WAIT discards the operation; 1 beats 3 afterwards.
        apply_stimulus(0, 8'h01, 8'h01, 3'b000);
        req_valid = 4'b0001;
        #1;
        check_output("midreset_ready", req_ready, 4'b0001);
        tick();
        apply_stimulus(1, 8'h07, 8'h02, 3'b001);
        apply_stimulus(3, 8'h09, 8'h09, 3'b000);
        req_valid = 4'b1010;
        tick();
        check_output("midreset_wait_busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_output("midreset_busy", busy, 1'b0);
        check_output("midreset_ready_held", req_ready, 4'b0000);
        check_output("midreset_alu_lhs", alu_lhs, 8'h00);
        check_output("midreset_alu_fn", alu_function, 3'b000);
        check_output("midreset_rsp_valid", rsp_valid, 1'b0);
        tick();
        check_output("midreset_rsp_held", rsp_valid, 1'b0);
        reset = 1'b0;
        alu_enable = 1'b1;
        #1;
        run_op("postreset", 1, 8'h05);
        req_valid = 4'b0000;
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
